// File: rtl/sha2_pkg.sv
// Shared types, constants and round functions for the SHA-256/224 core.
package sha2_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, HASH, UPDATE, DONE} state_t;
    typedef enum logic {SHA256, SHA224} mode_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(logic [31:0] x, logic [31:0] y,
                                       logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(logic [31:0] x, logic [31:0] y,
                                        logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic work_t iv_of(mode_t m);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v[255-32*i -: 32] = (m == SHA224) ? IV224[i] : IV256[i];
        end
        return work_t'(v);
    endfunction

    // Word-wise mod 2^32 sum; no carry crosses word boundaries.
    function automatic work_t add_work(work_t x, work_t y);
        logic [255:0] px;
        logic [255:0] py;
        logic [255:0] r;
        px = x;
        py = y;
        r  = '0;
        for (int i = 0; i < 8; i++) begin
            r[255-32*i -: 32] = px[255-32*i -: 32] + py[255-32*i -: 32];
        end
        return work_t'(r);
    endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2/256 compression round.
module sha2_round
    import sha2_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] kt,
    input  logic [31:0] wt,
    output work_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + kt + wt;
    assign t2 = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);

    assign nxt = '{
        a: t1 + t2,
        b: cur.a,
        c: cur.b,
        d: cur.c,
        e: cur.d + t1,
        f: cur.e,
        g: cur.f,
        h: cur.g
    };

endmodule

// File: rtl/sha2_core.sv
// SHA-256/224 block engine with valid/ready block input and
// a configurable number of compression rounds per clock.
module sha2_core
    import sha2_pkg::*;
#(
    parameter int BlockWidth     = 512,
    parameter int DigestWidth    = 256,
    parameter int RoundsPerCycle = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [BlockWidth-1:0]  block_i,
    input  logic                   block_valid_i,
    output logic                   block_ready_o,
    input  logic                   last_i,
    input  logic                   mode_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   digest_valid_o
);

    if (BlockWidth != 512) begin : g_bad_block
        $error("sha2_core: BlockWidth must be 512");
    end
    if (DigestWidth != 256) begin : g_bad_digest
        $error("sha2_core: DigestWidth must be 256");
    end
    if (RoundsPerCycle != 1 && RoundsPerCycle != 2 &&
        RoundsPerCycle != 4) begin : g_bad_rounds
        $error("sha2_core: RoundsPerCycle must be 1, 2 or 4");
    end

    state_t                 state;
    mode_t                  mode;
    work_t                  hs;
    work_t                  ws;
    logic [31:0]            win [16];
    logic [6:0]             cnt;
    logic                   last;
    logic                   ready;
    logic                   busy;
    logic                   dvalid;
    logic [DigestWidth-1:0] digest;

    logic                   accept;
    logic [6:0]             cnt_nxt;
    logic [31:0]            blk_w [16];
    logic [31:0]            win_nxt [16];
    logic [31:0]            wt [RoundsPerCycle];
    logic [31:0]            kt [RoundsPerCycle];
    work_t                  rin [RoundsPerCycle];
    work_t                  rout [RoundsPerCycle];
    work_t                  h_sum;
    logic [255:0]           dig_nxt;

    assign accept  = block_valid_i & ready;
    assign cnt_nxt = cnt + 7'(RoundsPerCycle);
    assign h_sum   = add_work(hs, ws);
    assign dig_nxt = (mode == SHA224) ? {h_sum[255:32], 32'h0} : h_sum;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            blk_w[i] = block_i[BlockWidth-1-32*i -: 32];
        end
    end

    // Rolling schedule: slot 0 is always W[t]; each round appends W[t+16].
    always_comb begin
        logic [31:0] w [16];
        logic [31:0] s;
        w = win;
        s = '0;
        for (int r = 0; r < RoundsPerCycle; r++) begin
            wt[r] = w[0];
            s = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
            for (int i = 0; i < 15; i++) begin
                w[i] = w[i+1];
            end
            w[15] = s;
        end
        win_nxt = w;
    end

    for (genvar r = 0; r < RoundsPerCycle; r++) begin : g_rnd
        logic [5:0] t;
        assign t     = cnt[5:0] + 6'(r);
        assign kt[r] = K[t];
        if (r == 0) begin : g_head
            assign rin[r] = ws;
        end else begin : g_link
            assign rin[r] = rout[r-1];
        end
        sha2_round u_round (
            .cur (rin[r]),
            .kt  (kt[r]),
            .wt  (wt[r]),
            .nxt (rout[r])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            mode   <= SHA256;
            hs     <= iv_of(SHA256);
            ws     <= '0;
            win    <= '{default: '0};
            cnt    <= '0;
            last   <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            dvalid <= 1'b0;
            digest <= '0;
        end else if (abort_i) begin
            state  <= IDLE;
            mode   <= SHA256;
            hs     <= iv_of(SHA256);
            ready  <= 1'b1;
            busy   <= 1'b0;
            dvalid <= 1'b0;
            digest <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mode   <= mode_t'(mode_i);
                        hs     <= iv_of(mode_t'(mode_i));
                        ws     <= iv_of(mode_t'(mode_i));
                        win    <= blk_w;
                        last   <= last_i;
                        cnt    <= '0;
                        state  <= HASH;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        dvalid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (accept) begin
                        ws    <= hs;
                        win   <= blk_w;
                        last  <= last_i;
                        cnt   <= '0;
                        state <= HASH;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                HASH: begin
                    ws  <= rout[RoundsPerCycle-1];
                    win <= win_nxt;
                    cnt <= cnt_nxt;
                    if (cnt_nxt == 7'd64) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    hs    <= h_sum;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    if (last) begin
                        state  <= DONE;
                        dvalid <= 1'b1;
                        digest <= dig_nxt;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign block_ready_o  = ready;
    assign busy_o         = busy;
    assign digest_o       = digest;
    assign digest_valid_o = dvalid;

endmodule

// File: doc/sha2_core.md
Name: sha2_core

Overview:
- Parametrised successor to the team's SHA-1 core: a SHA-2/256-family hash engine supporting SHA-256 and SHA-224, selected per message at run time.
- Replaces in-band end-of-message byte detection with an explicit valid/ready block handshake and a last-block flag. Software supplies already-padded 512-bit blocks.
- Configurable rounds per cycle trades area for latency.
- Sits behind the same register front-end as the SHA-1 core.

Parameters:
- BlockWidth, 512, message block width; any other value is an elaboration error.
- DigestWidth, 256, digest output width; any other value is an elaboration error.
- RoundsPerCycle, 1, compression rounds evaluated per clock; legal values are 1, 2 and 4, anything else is an elaboration error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- block_i  in  BlockWidth  padded block; word W0 = block_i[511:480], W15 = block_i[31:0]
- block_valid_i  in  1  block_i is valid
- block_ready_o  out  1  core can accept a block
- last_i  in  1  accepted block is the final block of the message
- mode_i  in  1  0 = SHA-256, 1 = SHA-224; sampled only on the first block of a message
- abort_i  in  1  synchronous abort of the current message
- busy_o  out  1  compression in progress
- digest_o  out  DigestWidth  digest; in SHA-224 mode [255:32] = H0..H6 and [31:0] = 0
- digest_valid_o  out  1  digest_o holds the final digest of the last message

Behaviour:
- Reset values:
  - state IDLE
  - block_ready_o = 1
  - busy_o = 0
  - digest_valid_o = 0
  - digest_o = 0
  - chaining H0..H7 = SHA-256 IV
  - mode register = 0
- block_ready_o is a function of registered state only. It is 1 in IDLE, WAIT and DONE, and 0 in HASH and UPDATE.
- Accept means block_valid_i & block_ready_o & ~abort_i.
- States:
  - IDLE: on accept, capture mode_i and load chaining and working vars a..h with the IV for that mode. Load the 16-word schedule window from block_i, latch last_i, go to HASH.
  - WAIT (between blocks of one message): on accept, load the window and latch last_i. a..h are taken from the current chaining, and mode is unchanged. Go to HASH.
  - HASH:
    - Execute RoundsPerCycle rounds per cycle.
    - Round counter is 7 bits, reset to 0 on accept, incremented by RoundsPerCycle.
    - For t < 16, Wt comes from the window. For t >= 16, Wt = s1(Wt-2) + Wt-7 + s0(Wt-15) + Wt-16 (mod 2^32), computed in place into a rolling 16-word window.
    - When the counter reaches 64, go to UPDATE.
  - UPDATE (1 cycle): Hi <= Hi + working var (mod 2^32). Then go to DONE if last was latched, else to WAIT.
  - DONE: digest_valid_o = 1 and digest_o holds the final chaining. An accept here starts a new message exactly as from IDLE. digest_valid_o drops in the cycle after that accept.
- Latency: accept in cycle N gives digest_valid_o = 1 in cycle N + 64/RoundsPerCycle + 2. With RoundsPerCycle = 1 that is N + 66.
- busy_o = 1 in HASH and UPDATE.
- digest_o is registered and updated only on the transition into DONE. It is held stable while in DONE.
- In WAIT, digest_valid_o = 0 and digest_o keeps its previous value.
- abort_i, in any state:
  - next state is IDLE and digest_valid_o = 0 the next cycle;
  - digest_o is cleared to 0;
  - chaining is reset to the SHA-256 IV;
  - abort takes priority over a simultaneous accept, and that block is discarded.
- Reset mid-HASH: everything returns to its reset values asynchronously, and no partial digest is visible.
- block_valid_i while not ready is ignored, and the block is not captured later. The producer must hold the block until it sees ready.
- mode_i and last_i are don't-care when no accept occurs.
- All arithmetic is mod 2^32 with no carry-out. Schedule and round rotations follow FIPS 180-4.

Decomposition:
- Package sha2_pkg holds:
  - state enum: IDLE, WAIT, HASH, UPDATE, DONE;
  - mode enum: SHA256, SHA224;
  - K[0:63] constant array;
  - IV256 and IV224 arrays;
  - functions ch, maj, bsig0, bsig1, ssig0, ssig1.
- Sub-module sha2_round: a combinational single-round datapath taking a..h, Kt and Wt and returning the next a..h. The core instantiates it RoundsPerCycle times in a chain.

Test Plan:
- SHA-256 of "abc" (1 padded block, last_i = 1, mode_i = 0) -> digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. digest_valid_o rises exactly 66 cycles after accept at RoundsPerCycle = 1.
- SHA-224 of "abc" -> digest_o[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, and [31:0] = 0.
- Two-block SHA-256 of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", with block_valid_i gapped 5 cycles in WAIT -> digest_o = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, and digest_valid_o stays 0 in WAIT.
- Empty-message SHA-256 started from DONE of the previous test, back-to-back -> digest_valid_o drops one cycle after accept, then digest_o = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- abort_i pulsed at round 30 of a two-block message, then "abc" SHA-256 -> busy_o = 0 the next cycle, digest_o = 0, and the correct "abc" digest follows (no stale chaining).
- Repeat the first three tests with RoundsPerCycle = 2 and 4 -> identical digests, with latency 34 and 18 cycles respectively. Assert on the waveform that block_ready_o = 0 throughout HASH and UPDATE.
